// File: rtl/s27_fi_ctrl.sv
// Fault-injection campaign controller for the s27 benchmark: sequences reset/run phases,
// drives LFSR stimulus and a one-shot fault strobe, and tallies runs whose G17 diverged.
module s27_fi_ctrl #(
    parameter int unsigned CYC_W   = 8,
    parameter int unsigned RUN_W   = 16,
    parameter int unsigned RST_CYC = 2,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic [RUN_W-1:0] num_runs,
    input  logic [CYC_W-1:0] run_len,
    input  logic [CYC_W-1:0] inj_cycle,
    input  logic [1:0]       inj_target,
    input  logic             dut_out,
    input  logic             gold_out,
    output logic             dut_rst,
    output logic [3:0]       dut_in,
    output logic             fault_en,
    output logic [2:0]       fault_sel,
    output logic             busy,
    output logic             done,
    output logic [RUN_W-1:0] fail_runs,
    output logic [RUN_W-1:0] first_fail,
    output logic             fail_seen
);

    localparam int unsigned RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic [RUN_W-1:0] run_idx_q, run_idx_d;
    logic [RUN_W-1:0] num_runs_q, num_runs_d;
    logic [CYC_W-1:0] run_len_q, run_len_d;
    logic [CYC_W-1:0] inj_cycle_q, inj_cycle_d;
    logic [1:0]       inj_target_q, inj_target_d;
    logic             run_fail_q, run_fail_d;
    logic [RUN_W-1:0] fail_runs_q, fail_runs_d;
    logic [RUN_W-1:0] first_fail_q, first_fail_d;
    logic             fail_seen_q, fail_seen_d;
    logic             mismatch;
    logic             run_failed;

    assign mismatch   = dut_out ^ gold_out;
    // The last RUN cycle's own compare has not landed in run_fail_q yet.
    assign run_failed = run_fail_q | mismatch;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cyc_d        = cyc_q;
        rcnt_d       = rcnt_q;
        run_idx_d    = run_idx_q;
        num_runs_d   = num_runs_q;
        run_len_d    = run_len_q;
        inj_cycle_d  = inj_cycle_q;
        inj_target_d = inj_target_q;
        run_fail_d   = run_fail_q;
        fail_runs_d  = fail_runs_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_runs_d   = num_runs;
                    run_len_d    = run_len;
                    inj_cycle_d  = inj_cycle;
                    inj_target_d = inj_target;
                    lfsr_d       = SEED;
                    fail_runs_d  = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                    run_idx_d    = '0;
                    rcnt_d       = '0;
                    if (num_runs == '0 || run_len == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StReset;
                    end
                end
            end
            StReset: begin
                if (rcnt_q == RC_W'(RST_CYC - 1)) begin
                    state_d    = StRun;
                    cyc_d      = '0;
                    run_fail_d = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + RC_W'(1);
                end
            end
            StRun: begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                cyc_d  = cyc_q + CYC_W'(1);
                if (mismatch) begin
                    run_fail_d = 1'b1;
                end
                if (cyc_q == run_len_q - CYC_W'(1)) begin
                    if (run_failed) begin
                        if (fail_runs_q != '1) begin
                            fail_runs_d = fail_runs_q + RUN_W'(1);
                        end
                        if (!fail_seen_q) begin
                            first_fail_d = run_idx_q;
                            fail_seen_d  = 1'b1;
                        end
                    end
                    run_idx_d = run_idx_q + RUN_W'(1);
                    rcnt_d    = '0;
                    if (run_idx_q + RUN_W'(1) == num_runs_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StReset;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            lfsr_q       <= SEED;
            cyc_q        <= '0;
            rcnt_q       <= '0;
            run_idx_q    <= '0;
            num_runs_q   <= '0;
            run_len_q    <= '0;
            inj_cycle_q  <= '0;
            inj_target_q <= 2'd3;
            run_fail_q   <= 1'b0;
            fail_runs_q  <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cyc_q        <= cyc_d;
            rcnt_q       <= rcnt_d;
            run_idx_q    <= run_idx_d;
            num_runs_q   <= num_runs_d;
            run_len_q    <= run_len_d;
            inj_cycle_q  <= inj_cycle_d;
            inj_target_q <= inj_target_d;
            run_fail_q   <= run_fail_d;
            fail_runs_q  <= fail_runs_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    always_comb begin
        dut_rst   = (state_q != StRun);
        busy      = (state_q == StReset) || (state_q == StRun);
        done      = (state_q == StDone);
        dut_in    = lfsr_q[3:0];
        fault_en  = (state_q == StRun) && (inj_target_q != 2'd3) && (cyc_q == inj_cycle_q);
        fault_sel = 3'b000;
        if (fault_en) begin
            fault_sel = 3'b001 << inj_target_q;
        end
    end

    assign fail_runs  = fail_runs_q;
    assign first_fail = first_fail_q;
    assign fail_seen  = fail_seen_q;

endmodule

// File: tb/tb_s27_fi_ctrl.sv
// Randomised bench for s27_fi_ctrl: a cycle-schedule reference model predicts every output
// from the campaign timeline arithmetic and the LFSR recurrence.
module tb_s27_fi_ctrl;

    localparam int RST_CYC = 2;

    logic        CK;
    logic        RST;
    logic        start;
    logic [15:0] num_runs;
    logic [7:0]  run_len;
    logic [7:0]  inj_cycle;
    logic [1:0]  inj_target;
    logic        dut_out;
    logic        gold_out;
    logic        dut_rst;
    logic [3:0]  dut_in;
    logic        fault_en;
    logic [2:0]  fault_sel;
    logic        busy;
    logic        done;
    logic [15:0] fail_runs;
    logic [15:0] first_fail;
    logic        fail_seen;

    int tests;
    int fails;
    logic [3:0] run_nibs[$];

    s27_fi_ctrl u_dut (
        .CK         (CK),
        .RST        (RST),
        .start      (start),
        .num_runs   (num_runs),
        .run_len    (run_len),
        .inj_cycle  (inj_cycle),
        .inj_target (inj_target),
        .dut_out    (dut_out),
        .gold_out   (gold_out),
        .dut_rst    (dut_rst),
        .dut_in     (dut_in),
        .fault_en   (fault_en),
        .fault_sel  (fault_sel),
        .busy       (busy),
        .done       (done),
        .fail_runs  (fail_runs),
        .first_fail (first_fail),
        .fail_seen  (fail_seen)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // LFSR state after n RUN cycles of a campaign.
    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] x;
        x = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
        end
        return x;
    endfunction

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // mode 0: outputs always agree; 1: random mismatch with pct%; 2: mismatch only in
    // the last cycle of run 2.
    task automatic campaign(input int nr, input int rl, input int ic, input int it,
                            input int mode, input int pct, output int fe_cnt);
        int neff, per, r, off, cyc, nfail, first;
        bit rfail[8];
        bit m, seen;
        logic [15:0] lf;
        logic [10:0] expv, obsv;
        neff = (rl == 0) ? 0 : nr;
        per = RST_CYC + rl;
        fe_cnt = 0;
        run_nibs.delete();
        for (int i = 0; i < 8; i++) rfail[i] = 1'b0;
        num_runs = 16'(nr);
        run_len = 8'(rl);
        inj_cycle = 8'(ic);
        inj_target = 2'(it);
        start = 1'b1;
        step();
        for (int t = 0; t <= neff * per + 1; t++) begin
            r = 0;
            cyc = -1;
            if (t < neff * per) begin
                r = t / per;
                off = t % per;
                if (off < RST_CYC) begin
                    lf = lfsr_at(r * rl);
                    expv = {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, lf[3:0]};
                end else begin
                    cyc = off - RST_CYC;
                    lf = lfsr_at(r * rl + cyc);
                    if (it != 3 && cyc == ic) begin
                        expv = {1'b0, 1'b1, 1'b0, 1'b1, 3'(1 << it), lf[3:0]};
                    end else begin
                        expv = {1'b0, 1'b1, 1'b0, 1'b0, 3'b000, lf[3:0]};
                    end
                end
            end else begin
                lf = lfsr_at(neff * rl);
                expv = {1'b1, 1'b0, (t == neff * per), 1'b0, 3'b000, lf[3:0]};
            end
            obsv = {dut_rst, busy, done, fault_en, fault_sel, dut_in};
            if (fault_en === 1'b1) fe_cnt++;
            if (cyc >= 0) run_nibs.push_back(dut_in);
            tests++;
            if (obsv !== expv) begin
                fails++;
                $display("FAIL cycle t=%0d nr=%0d rl=%0d: {rst,busy,done,fe,sel,in} got %b want %b",
                         t, nr, rl, obsv, expv);
            end
            m = 1'b0;
            if (cyc >= 0) begin
                if (mode == 1) m = ($urandom_range(0, 99) < pct);
                if (mode == 2) m = (r == 2 && cyc == rl - 1);
                if (m) rfail[r] = 1'b1;
            end
            dut_out = 1'($urandom);
            gold_out = dut_out ^ m;
            start = (t <= neff * per) ? 1'($urandom) : 1'b0;
            step();
        end
        nfail = 0;
        first = 0;
        seen = 1'b0;
        for (int i = 0; i < neff; i++) begin
            if (rfail[i]) begin
                if (!seen) first = i;
                seen = 1'b1;
                nfail++;
            end
        end
        tests++;
        if (fail_runs !== 16'(nfail) || fail_seen !== seen ||
            first_fail !== (seen ? 16'(first) : 16'd0)) begin
            fails++;
            $display("FAIL results nr=%0d rl=%0d: runs/seen/first got %0d/%0b/%0d want %0d/%0b/%0d",
                     nr, rl, fail_runs, fail_seen, first_fail, nfail, seen, first);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({dut_rst, busy, done, fault_en, fault_sel, fail_runs, first_fail, fail_seen}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0, 16'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset: rst=%b busy=%b done=%b fe=%b sel=%b runs=%0d first=%0d seen=%b want 1 0 0 0 000 0 0 0",
                     dut_rst, busy, done, fault_en, fault_sel, fail_runs, first_fail, fail_seen);
        end
    endtask

    task automatic test_no_fault();
        int fe;
        campaign(3, 4, 0, 3, 0, 0, fe);
        tests++;
        if (fe != 0) begin
            fails++;
            $display("FAIL no_fault strobe count got %0d want 0", fe);
        end
    endtask

    task automatic test_injection();
        int fe;
        campaign(1, 8, 5, 1, 0, 0, fe);
        tests++;
        if (fe != 1) begin
            fails++;
            $display("FAIL inj_cycle5 strobe count got %0d want 1", fe);
        end
        campaign(1, 8, 8, 1, 0, 0, fe);
        tests++;
        if (fe != 0) begin
            fails++;
            $display("FAIL inj_cycle8 strobe count got %0d want 0", fe);
        end
    endtask

    task automatic test_fail_run2();
        int fe;
        campaign(4, 5, 2, 2, 2, 0, fe);
        tests++;
        if (fail_runs !== 16'd1 || first_fail !== 16'd2 || fail_seen !== 1'b1) begin
            fails++;
            $display("FAIL run2 result got runs=%0d first=%0d seen=%b want 1 2 1",
                     fail_runs, first_fail, fail_seen);
        end
    endtask

    task automatic test_zero_runs();
        int fe;
        campaign(0, 5, 0, 0, 1, 50, fe);
        campaign(3, 0, 0, 0, 1, 50, fe);
    endtask

    task automatic test_lfsr();
        int fe;
        logic [3:0] want[3];
        want[0] = 4'h1;
        want[1] = 4'h3;
        want[2] = 4'h7;
        for (int k = 0; k < 2; k++) begin
            campaign(1, 3, 9, 3, 0, 0, fe);
            tests++;
            if (run_nibs.size() != 3 || run_nibs[0] !== want[0] || run_nibs[1] !== want[1] ||
                run_nibs[2] !== want[2]) begin
                fails++;
                $display("FAIL lfsr pass %0d: got %p want 1 3 7", k, run_nibs);
            end
        end
    endtask

    task automatic test_mid_reset();
        int fe;
        num_runs = 16'd2;
        run_len = 8'd6;
        inj_cycle = 8'd1;
        inj_target = 2'd0;
        dut_out = 1'b1;
        gold_out = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2 * RST_CYC + 8) step();
        tests++;
        if (fail_runs !== 16'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pre_abort got runs=%0d busy=%b want 1 1", fail_runs, busy);
        end
        #2 RST = 1'b0;
        #1;
        tests++;
        if ({dut_rst, busy, fault_en, done, fail_runs} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL abort got rst=%b busy=%b fe=%b done=%b runs=%0d want 1 0 0 0 0",
                     dut_rst, busy, fault_en, done, fail_runs);
        end
        dut_out = 1'b0;
        gold_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_hold %0d got done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        RST = 1'b1;
        step();
        campaign(2, 6, 1, 0, 1, 30, fe);
    endtask

    task automatic test_random();
        int fe;
        for (int k = 0; k < 8; k++) begin
            campaign($urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 8),
                     $urandom_range(0, 3), 1, 15, fe);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RST = 1'b0;
        start = 1'b0;
        num_runs = '0;
        run_len = '0;
        inj_cycle = '0;
        inj_target = '0;
        dut_out = 1'b0;
        gold_out = 1'b0;
        repeat (3) step();
        test_reset();
        RST = 1'b1;
        step();
        test_reset();
        test_no_fault();
        test_injection();
        test_fail_run2();
        test_zero_runs();
        test_lfsr();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
